// File: rtl/decode_stage.sv
// Decode stage: splits fetched instructions, reads operands, stalls on RAW hazards via a
// destination-register scoreboard. Define DECODE_WB_BYPASS_EN to forward same-cycle writebacks.
module decode_stage #(
    parameter int XLEN    = 16,
    parameter int REG_AW  = 3,
    parameter int FUNCT_W = 5,
    parameter int ILEN    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ILEN-1:0]          in_instr,
    output logic [REG_AW-1:0]        rf_raddr1,
    output logic [REG_AW-1:0]        rf_raddr2,
    input  logic [XLEN-1:0]          rf_rdata1,
    input  logic [XLEN-1:0]          rf_rdata2,
    input  logic                     wb_valid,
    input  logic [REG_AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_opcode,
    output logic [FUNCT_W-1:0]       out_alu_ctrl,
    output logic [XLEN-1:0]          out_src1,
    output logic [XLEN-1:0]          out_src2,
    output logic                     out_wen,
    output logic [REG_AW-1:0]        out_waddr,
    output logic [(2**REG_AW)-1:0]   busy_mask,
    output logic [15:0]              stall_cnt
);
    localparam int NREG    = 2**REG_AW;
    localparam int FN_LSB  = XLEN;
    localparam int IV_BIT  = XLEN + FUNCT_W;
    localparam int SRC_LSB = IV_BIT + 1;
    localparam int DST_LSB = SRC_LSB + REG_AW;
    localparam int OP_LSB  = DST_LSB + REG_AW;

    logic [3:0]         in_op;
    logic [REG_AW-1:0]  in_dest;
    logic [REG_AW-1:0]  in_src;
    logic               in_imm_valid;
    logic [FUNCT_W-1:0] in_funct;
    logic [XLEN-1:0]    in_imm;

    assign in_op        = in_instr[OP_LSB +: 4];
    assign in_dest      = in_instr[DST_LSB +: REG_AW];
    assign in_src       = in_instr[SRC_LSB +: REG_AW];
    assign in_imm_valid = in_instr[IV_BIT];
    assign in_funct     = in_instr[FN_LSB +: FUNCT_W];
    assign in_imm       = in_instr[XLEN-1:0];

    assign rf_raddr1 = in_dest;
    assign rf_raddr2 = in_src;

    logic                     out_valid_q, out_valid_d;
    logic [3:0]               out_opcode_q, out_opcode_d;
    logic [FUNCT_W-1:0]       out_alu_ctrl_q, out_alu_ctrl_d;
    logic [XLEN-1:0]          out_src1_q, out_src1_d;
    logic [XLEN-1:0]          out_src2_q, out_src2_d;
    logic                     out_wen_q, out_wen_d;
    logic [REG_AW-1:0]        out_waddr_q, out_waddr_d;
    logic [NREG-1:0]          busy_q, busy_d;
    logic [15:0]              stall_cnt_q, stall_cnt_d;

    logic            dest_busy, src_busy;
    logic [XLEN-1:0] opnd1, reg2;

`ifdef DECODE_WB_BYPASS_EN
    logic dest_wb, src_wb;
    assign dest_wb   = wb_valid && (wb_addr == in_dest);
    assign src_wb    = wb_valid && (wb_addr == in_src);
    assign dest_busy = busy_q[in_dest] && !dest_wb;
    assign src_busy  = busy_q[in_src] && !src_wb;
    assign opnd1     = dest_wb ? wb_data : rf_rdata1;
    assign reg2      = src_wb ? wb_data : rf_rdata2;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign dest_busy      = busy_q[in_dest];
    assign src_busy       = busy_q[in_src];
    assign opnd1          = rf_rdata1;
    assign reg2           = rf_rdata2;
`endif

    // The packet sitting in the output register has not set its busy bit yet.
    logic dest_fwd, src_fwd, hazard, accept, issue;
    assign dest_fwd = out_valid_q && out_wen_q && (out_waddr_q == in_dest);
    assign src_fwd  = out_valid_q && out_wen_q && (out_waddr_q == in_src);
    assign hazard   = in_valid && (dest_busy || dest_fwd ||
                                   (!in_imm_valid && (src_busy || src_fwd)));
    assign in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid_q && out_ready && out_wen_q && !flush;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_opcode_d   = out_opcode_q;
        out_alu_ctrl_d = out_alu_ctrl_q;
        out_src1_d     = out_src1_q;
        out_src2_d     = out_src2_q;
        out_wen_d      = out_wen_q;
        out_waddr_d    = out_waddr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d    = 1'b1;
            out_opcode_d   = in_op;
            out_alu_ctrl_d = in_funct;
            out_src1_d     = opnd1;
            out_src2_d     = in_imm_valid ? in_imm : reg2;
            out_wen_d      = (in_op == 4'b0001) || (in_op == 4'b0010);
            out_waddr_d    = in_dest;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Set after clear so a same-cycle issue keeps the register busy.
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_addr] = 1'b0;
        if (issue)    busy_d[out_waddr_q] = 1'b1;

        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_opcode_q   <= '0;
            out_alu_ctrl_q <= '0;
            out_src1_q     <= '0;
            out_src2_q     <= '0;
            out_wen_q      <= 1'b0;
            out_waddr_q    <= '0;
            busy_q         <= '0;
            stall_cnt_q    <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_opcode_q   <= out_opcode_d;
            out_alu_ctrl_q <= out_alu_ctrl_d;
            out_src1_q     <= out_src1_d;
            out_src2_q     <= out_src2_d;
            out_wen_q      <= out_wen_d;
            out_waddr_q    <= out_waddr_d;
            busy_q         <= busy_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_opcode   = out_opcode_q;
    assign out_alu_ctrl = out_alu_ctrl_q;
    assign out_src1     = out_src1_q;
    assign out_src2     = out_src2_q;
    assign out_wen      = out_wen_q;
    assign out_waddr    = out_waddr_q;
    assign busy_mask    = busy_q;
    assign stall_cnt    = stall_cnt_q;
endmodule
